// File: rtl/dot2_pkg.sv
// Shared constants for the two-term dot-product pipeline.
// LATENCY follows the DOT2_INPUT_REG_EN build option so benches can align expectations.
package dot2_pkg;

    localparam int DOT2_WIDTH = 32;

`ifdef DOT2_INPUT_REG_EN
    localparam int LATENCY = 3;
`else
    localparam int LATENCY = 2;
`endif

endpackage

// File: rtl/dot2_mul_stage.sv
// Registered truncating unsigned multiplier: p = (a*b) mod 2^WIDTH, one cycle latency.
// The product and the valid flag both clear on reset.
module dot2_mul_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] p
);

    // Only the low WIDTH bits of the product are kept; upper bits are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p         <= '0;
            out_valid <= 1'b0;
        end else begin
            p         <= a * b;
            out_valid <= in_valid;
        end
    end

endmodule

// File: rtl/dot2_mac_pipeline.sv
// Streaming C = A1*B1 + A2*B2 (unsigned, mod 2^WIDTH), one operand set per clock, no stalls.
// Define DOT2_INPUT_REG_EN to add an input register stage (latency 3 instead of 2).
module dot2_mac_pipeline
    import dot2_pkg::*;
#(
    parameter int WIDTH = DOT2_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] B1,
    input  logic [WIDTH-1:0] A2,
    input  logic [WIDTH-1:0] B2,
    output logic             out_valid,
    output logic [WIDTH-1:0] C
);

    logic [WIDTH-1:0] a1_s, b1_s, a2_s, b2_s;
    logic             vin_s;

`ifdef DOT2_INPUT_REG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1_s  <= '0;
            b1_s  <= '0;
            a2_s  <= '0;
            b2_s  <= '0;
            vin_s <= 1'b0;
        end else begin
            a1_s  <= A1;
            b1_s  <= B1;
            a2_s  <= A2;
            b2_s  <= B2;
            vin_s <= in_valid;
        end
    end
`else
    assign a1_s  = A1;
    assign b1_s  = B1;
    assign a2_s  = A2;
    assign b2_s  = B2;
    assign vin_s = in_valid;
`endif

    logic [WIDTH-1:0] p1, p2;
    logic             v1_a, v1_b;

    dot2_mul_stage #(.WIDTH(WIDTH)) u_mul1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (vin_s),
        .a         (a1_s),
        .b         (b1_s),
        .out_valid (v1_a),
        .p         (p1)
    );

    dot2_mul_stage #(.WIDTH(WIDTH)) u_mul2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (vin_s),
        .a         (a2_s),
        .b         (b2_s),
        .out_valid (v1_b),
        .p         (p2)
    );

    // Both multipliers see the same valid, so either flag would do; ANDing keeps both in use.
    logic v1;
    assign v1 = v1_a & v1_b;

    // Add stage: carry out of the sum is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            C         <= '0;
            out_valid <= 1'b0;
        end else begin
            C         <= p1 + p2;
            out_valid <= v1;
        end
    end

endmodule

// File: tb/tb_dot2_mac_pipeline.sv
// Directed bench for dot2_mac_pipeline: hand-computed results delayed by LATENCY in a small
// delay line, compared on the falling edge.
module tb_dot2_mac_pipeline;
    import dot2_pkg::*;

    localparam int W = DOT2_WIDTH;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] A1 = '0, B1 = '0, A2 = '0, B2 = '0;
    logic         out_valid;
    logic [W-1:0] C;

    int n_checks = 0;
    int n_errors = 0;

    logic         hv [LATENCY];
    logic [W-1:0] hc [LATENCY];
    string        ht [LATENCY];

    always #5 clk = ~clk;

    dot2_mac_pipeline dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A1        (A1),
        .B1        (B1),
        .A2        (A2),
        .B2        (B2),
        .out_valid (out_valid),
        .C         (C)
    );

    task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < LATENCY; i++) begin
            hv[i] = 1'b0;
            hc[i] = '0;
            ht[i] = "idle";
        end
    endtask

    // One clock: drive operands now (falling edge), advance the model at the rising edge,
    // compare on the next falling edge.
    task automatic step(input string tag, input logic v, input logic [W-1:0] a1,
                        input logic [W-1:0] b1, input logic [W-1:0] a2,
                        input logic [W-1:0] b2, input logic [W-1:0] e);
        in_valid = v;
        A1 = a1; B1 = b1; A2 = a2; B2 = b2;
        @(posedge clk);
        for (int i = LATENCY - 1; i > 0; i--) begin
            hv[i] = hv[i-1];
            hc[i] = hc[i-1];
            ht[i] = ht[i-1];
        end
        hv[0] = v;
        hc[0] = e;
        ht[0] = tag;
        @(negedge clk);
        check_val({ht[LATENCY-1], "_vld"}, W'(out_valid), W'(hv[LATENCY-1]));
        if (hv[LATENCY-1])
            check_val({ht[LATENCY-1], "_c"}, C, hc[LATENCY-1]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step("idle", 1'b0, '0, '0, '0, '0, '0);
    endtask

    // Clock while reset is held: inputs toggle but outputs must stay zero.
    task automatic rst_step(input string tag);
        in_valid = 1'($urandom_range(0, 1));
        A1 = W'($urandom); B1 = W'($urandom);
        A2 = W'($urandom); B2 = W'($urandom);
        @(posedge clk);
        @(negedge clk);
        check_val({tag, "_c"}, C, '0);
        check_val({tag, "_vld"}, W'(out_valid), '0);
    endtask

    initial begin
        clear_model();

        // Reset held with toggling inputs, then release with in_valid low.
        for (int i = 0; i < 4; i++)
            rst_step("rst_hold");
        in_valid = 1'b0;
        rst_n = 1'b1;
        idle(3);

        // Basic single set.
        step("basic", 1'b1, 32'd1, 32'd3, 32'd2, 32'd4, 32'd11);
        idle(LATENCY);

        // Back-to-back, order preserved with no bubble.
        step("b2b_a", 1'b1, 32'd1, 32'd3, 32'd2, 32'd4, 32'd11);
        step("b2b_b", 1'b1, 32'd1, 32'd1, 32'd0, 32'd0, 32'd1);
        idle(LATENCY);

        // Truncated product and dropped sum carry.
        step("wrap_sum", 1'b1, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'd3, 32'h0000_0001);
        step("wrap_prod", 1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0);
        idle(LATENCY);

        // Alternating valid with distinct operands.
        step("gap0", 1'b1, 32'd5, 32'd6, 32'd7, 32'd8, 32'd86);
        step("gap1", 1'b0, 32'd9, 32'd9, 32'd9, 32'd9, 32'd162);
        step("gap2", 1'b1, 32'd10, 32'd11, 32'd12, 32'd13, 32'd266);
        step("gap3", 1'b0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd2);
        step("gap4", 1'b1, 32'd100, 32'd200, 32'd300, 32'd400, 32'd140000);
        step("gap5", 1'b0, 32'd7, 32'd7, 32'd7, 32'd7, 32'd98);
        step("gap6", 1'b1, 32'h1234_5678, 32'h10, 32'd0, 32'd0, 32'h2345_6780);
        idle(LATENCY + 1);

        // Mid-stream asynchronous reset between edges.
        step("mid0", 1'b1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd26);
        step("mid1", 1'b1, 32'd6, 32'd7, 32'd8, 32'd9, 32'd114);
        step("mid2", 1'b1, 32'h0000_FFFF, 32'h0000_FFFF, 32'd1, 32'd1, 32'hFFFE_0002);
        step("mid3", 1'b1, 32'd3, 32'd3, 32'd3, 32'd3, 32'd18);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst_c", C, '0);
        check_val("async_rst_vld", W'(out_valid), '0);
        clear_model();
        rst_step("mid_rst");
        rst_step("mid_rst");
        in_valid = 1'b0;
        rst_n = 1'b1;
        idle(LATENCY + 2);

        // Fresh traffic after the mid-stream reset.
        step("post_mid", 1'b1, 32'd4, 32'd4, 32'd5, 32'd5, 32'd41);
        idle(LATENCY);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dot2_mac_pipeline.md
Name: dot2_mac_pipeline

Overview:
- Pipelined two-term dot-product unit: C = A1*B1 + A2*B2.
- Unsigned, modulo 2^WIDTH.
- Accepts one operand set per clock, with no stalls.
- Multiply stage feeds an add stage; used as a streaming arithmetic datapath example and building block.

Parameters:
- WIDTH, 32, bit width of every operand and of the result.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand set on A1/A2/B1/B2 is valid this cycle
- A1  input  WIDTH  first multiplicand, term 1
- B1  input  WIDTH  second multiplicand, term 1
- A2  input  WIDTH  first multiplicand, term 2
- B2  input  WIDTH  second multiplicand, term 2
- out_valid  output  1  C holds the result of a valid operand set
- C  output  WIDTH  dot-product result

Behaviour:
- Single clock domain.
- Reset: rst_n low clears all pipeline registers immediately, without waiting for a clock edge. While rst_n is low, C=0 and out_valid=0. Reset may be asserted mid-stream; every in-flight result is discarded. No output pulse occurs after rst_n is released until new valid inputs arrive.
- Stage 1 (clock edge k): register P1 = (A1*B1) mod 2^WIDTH and P2 = (A2*B2) mod 2^WIDTH; register v1 = in_valid.
- Stage 2 (edge k+1): register C = (P1+P2) mod 2^WIDTH; register out_valid = v1.
- Latency: 2 rising edges from operands sampled to C updated. Throughput: 1 result per cycle.
- Ordering: results leave in input order. Consecutive inputs are independent; there is no accumulation across cycles.
- Data path updates every cycle regardless of in_valid. C is meaningful only when out_valid=1. This keeps a testbench that ties in_valid high working unchanged.
- Overflow: product upper bits are dropped; the sum carry is dropped; no flags are produced.
- All arithmetic is unsigned; operands are treated as zero-extended.
- No backpressure: the downstream consumer must accept every out_valid cycle.

Optional Feature:
- Macro DOT2_INPUT_REG_EN.
- Defined: adds an input register stage, clearing on reset, that captures A1/A2/B1/B2/in_valid before the multipliers. Latency becomes 3 edges; arithmetic is unchanged. This is for timing closure when the operands arrive late.
- Undefined: the multipliers take the ports directly, with latency 2 as specified above.

Decomposition:
- Shared package dot2_pkg holds:
  - the default WIDTH constant;
  - the LATENCY constant (2, or 3 when DOT2_INPUT_REG_EN is defined), so benches align their expected values.
- One natural sub-module: dot2_mul_stage, a WIDTH-parameterised registered truncating multiplier with a reset-cleared output and valid. It is instantiated twice, once per term. The adder stage lives in the top module.

Test Plan:
- Reset: hold rst_n=0 for several cycles while the inputs toggle -> C=0 and out_valid=0 throughout. Deassert rst_n with in_valid=0 -> out_valid stays 0.
- Basic: A1=1, A2=2, B1=3, B2=4, in_valid=1 -> 2 edges later C=11 (0x0000000B) with out_valid=1.
- Back-to-back: cycle n sends (1,2,3,4); cycle n+1 sends A1=1, A2=0, B1=1, B2=0 -> C=11, then C=1 on consecutive cycles. No bubbles; order is preserved.
- Wrap-around:
  - A1=0xFFFFFFFF, B1=2, A2=1, B2=3 -> C=0x00000001, since the product truncates to 0xFFFFFFFE and 0xFFFFFFFE+3 wraps.
  - A1=A2=B1=B2=0x00010000 -> C=0.
- Mid-stream reset: stream 4 valid sets; pulse rst_n low asynchronously between edges -> C and out_valid drop to 0 at once, and no stale results appear after release.
- Valid gaps: alternate in_valid 1/0 with distinct operands -> the out_valid pattern is the in_valid pattern delayed by LATENCY, and C matches the reference model on every out_valid=1 cycle. Repeat this scenario with DOT2_INPUT_REG_EN defined, expecting LATENCY=3.
